// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB latch, destination decode and the register-file
// write port. Long-latency mul/div results retire out of order through the
// same port; a small IDLE/PENDING machine tracks the one outstanding result
// and raises wb_stall when the latched instruction must wait for it.
module writeback_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid_in,
  input  logic [31:0] insn_in,
  input  logic [31:0] o_in,
  input  logic [31:0] d_in,
  input  logic [31:0] pcPlus1_in,
  input  logic        exc_in,
  input  logic [2:0]  excCode_in,
  input  logic        md_resultRDY,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        wb_stall,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        md_busy,
  output logic [4:0]  md_pendingReg
);

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_LINK   = 5'd31;

  typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

  // MEM/WB latch
  logic        r_valid;
  logic [31:0] r_insn;
  logic [31:0] r_o;
  logic [31:0] r_d;
  logic [31:0] r_pc1;
  logic        r_exc;
  logic [2:0]  r_excCode;

  // Outstanding mul/div tracking
  state_t      r_state;
  logic [4:0]  r_pendReg;
  logic        r_isDiv;

  logic [4:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_aluop;
  logic        w_isMd;
  logic        w_dstWrite;
  logic [4:0]  w_dstReg;
  logic [31:0] w_dstData;
  logic        w_mdDone;
  logic        w_mdWrite;
  logic [4:0]  w_mdReg;
  logic [31:0] w_mdData;
  logic        w_waw;
  logic        w_stall;

  assign w_opcode = r_insn[31:27];
  assign w_rd     = r_insn[26:22];
  assign w_aluop  = r_insn[6:2];

  // Destination decode of the latched instruction; r0 writes are dropped
  always_comb begin
    w_dstWrite = 1'b0;
    w_dstReg   = 5'd0;
    w_dstData  = 32'd0;
    w_isMd     = 1'b0;
    if (r_valid) begin
      if (r_exc) begin
        w_dstWrite = 1'b1;
        w_dstReg   = REG_STATUS;
        w_dstData  = {29'd0, r_excCode};
      end else if (w_opcode == OP_ALU && (w_aluop == ALU_MUL || w_aluop == ALU_DIV)) begin
        w_isMd = 1'b1;
      end else if (w_opcode == OP_ALU || w_opcode == OP_ADDI) begin
        w_dstWrite = 1'b1;
        w_dstReg   = w_rd;
        w_dstData  = r_o;
      end else if (w_opcode == OP_LW) begin
        w_dstWrite = 1'b1;
        w_dstReg   = w_rd;
        w_dstData  = r_d;
      end else if (w_opcode == OP_JAL) begin
        w_dstWrite = 1'b1;
        w_dstReg   = REG_LINK;
        w_dstData  = r_pc1;
      end else if (w_opcode == OP_SETX) begin
        w_dstWrite = 1'b1;
        w_dstReg   = REG_STATUS;
        w_dstData  = {5'd0, r_insn[26:0]};
      end
    end
    if (w_dstReg == 5'd0) begin
      w_dstWrite = 1'b0;
      w_dstData  = 32'd0;
    end
  end

  // Multdiv completion: exception status goes to r30, otherwise the result to pendingReg
  assign w_mdDone  = (r_state == S_PEND) && md_resultRDY;
  assign w_mdWrite = w_mdDone && (md_exception || (r_pendReg != 5'd0));
  assign w_mdReg   = md_exception ? REG_STATUS : r_pendReg;
  assign w_mdData  = md_exception ? (r_isDiv ? 32'd5 : 32'd4) : md_result;

  // Hold the latch while a mul/div is outstanding and the latched entry would
  // collide on the write port, is itself a mul/div, or overwrites pendingReg early
  assign w_waw   = w_dstWrite && (w_dstReg == r_pendReg) && (r_pendReg != 5'd0);
  assign w_stall = (r_state == S_PEND) && r_valid &&
                   ((md_resultRDY && w_dstWrite) || w_isMd || (w_waw && !md_resultRDY));

  // Write-port arbitration: a completing mul/div takes priority
  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;
    if (w_mdDone) begin
      if (w_mdWrite) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = w_mdReg;
        data_writeReg    = w_mdData;
      end
    end else if (w_dstWrite && !w_stall) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = w_dstReg;
      data_writeReg    = w_dstData;
    end
  end

  assign wb_stall      = w_stall;
  assign md_busy       = (r_state == S_PEND);
  assign md_pendingReg = r_pendReg;

  // Latch valid bit: reset discards the entry, stall holds it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      r_valid <= wb_valid_in;
    end
  end

  // Latch payload: captured whenever the latch is accepting
  always_ff @(posedge clock) begin
    if (!w_stall) begin
      r_insn    <= insn_in;
      r_o       <= o_in;
      r_d       <= d_in;
      r_pc1     <= pcPlus1_in;
      r_exc     <= exc_in;
      r_excCode <= excCode_in;
    end
  end

  // IDLE/PENDING machine for the single outstanding mul/div
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pendReg <= 5'd0;
      r_isDiv   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_isMd && !w_stall) begin
        r_state   <= S_PEND;
        r_pendReg <= w_rd;
        r_isDiv   <= w_aluop[0];
      end
    end else begin
      if (md_resultRDY) begin
        r_state   <= S_IDLE;
        r_pendReg <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed scenarios with literal expectations
// followed by randomized traffic checked through a scoreboard fed by a
// transaction-level reference model.
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid_in;
  logic [31:0] insn_in, o_in, d_in, pcPlus1_in;
  logic        exc_in;
  logic [2:0]  excCode_in;
  logic        md_resultRDY;
  logic [31:0] md_result;
  logic        md_exception;
  logic        wb_stall, ctrl_writeEnable, md_busy;
  logic [4:0]  ctrl_writeReg, md_pendingReg;
  logic [31:0] data_writeReg;

  always #5 clock = ~clock;

  writeback_stage dut (
    .clock(clock), .reset(reset), .wb_valid_in(wb_valid_in), .insn_in(insn_in),
    .o_in(o_in), .d_in(d_in), .pcPlus1_in(pcPlus1_in), .exc_in(exc_in),
    .excCode_in(excCode_in), .md_resultRDY(md_resultRDY), .md_result(md_result),
    .md_exception(md_exception), .wb_stall(wb_stall), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .md_busy(md_busy),
    .md_pendingReg(md_pendingReg)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    bit          v;
    logic [31:0] insn;
    logic [31:0] o;
    logic [31:0] d;
    logic [31:0] pc;
    bit          exc;
    logic [2:0]  code;
  } txn_t;

  typedef struct packed {
    bit          stall;
    bit          busy;
    logic [4:0]  pend;
    bit          we;
  } stat_t;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  stat_t statq[$];
  wr_t   wq[$];

  // reference model state
  txn_t       m_lat;
  bit         m_pend;
  bit         m_div;
  logic [4:0] m_preg;
  bit         last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] alu);
    return {op, rd, 15'd0, alu, 2'd0};
  endfunction

  function automatic txn_t tx(input logic [31:0] insn, input logic [31:0] o,
                              input logic [31:0] d = '0, input logic [31:0] pc = '0,
                              input bit exc = 1'b0, input logic [2:0] code = '0);
    txn_t t;
    t.v = 1'b1; t.insn = insn; t.o = o; t.d = d; t.pc = pc; t.exc = exc; t.code = code;
    return t;
  endfunction

  function automatic txn_t bub();
    txn_t t;
    t = '0;
    return t;
  endfunction

  // What an instruction means to the register file: kind 0 = nothing,
  // 1 = write (r,dat), 2 = mul/div targeting r
  function automatic void meaning(input txn_t t, output int kind, output logic [4:0] r,
                                  output logic [31:0] dat);
    logic [4:0] op, rd, alu;
    op = t.insn[31:27]; rd = t.insn[26:22]; alu = t.insn[6:2];
    kind = 0; r = 0; dat = 0;
    if (t.v) begin
      if (t.exc) begin kind = 1; r = 30; dat = 32'(t.code); end
      else if (op == 0 && (alu == 6 || alu == 7)) begin kind = 2; r = rd; end
      else if (op == 0 || op == 5) begin kind = 1; r = rd; dat = t.o; end
      else if (op == 8)  begin kind = 1; r = rd; dat = t.d; end
      else if (op == 3)  begin kind = 1; r = 31; dat = t.pc; end
      else if (op == 21) begin kind = 1; r = 30; dat = 32'(t.insn[26:0]); end
      if (kind == 1 && r == 0) begin kind = 0; dat = 0; end
    end
  endfunction

  // One clock cycle: drive inputs, predict this cycle's outputs, advance the model
  task automatic step(input txn_t t, input bit rdy = 1'b0, input logic [31:0] res = '0,
                      input bit mexc = 1'b0);
    int kind;
    logic [4:0] r;
    logic [31:0] dat;
    stat_t s;
    wr_t w;
    bit stall;
    @(posedge clock); #1;
    wb_valid_in = t.v; insn_in = t.insn; o_in = t.o; d_in = t.d; pcPlus1_in = t.pc;
    exc_in = t.exc; excCode_in = t.code;
    md_resultRDY = rdy; md_result = res; md_exception = mexc;
    meaning(m_lat, kind, r, dat);
    stall = 1'b0;
    s = '0;
    if (m_pend && rdy) begin
      stall = (kind != 0);
      if (mexc) begin s.we = 1; w.r = 30; w.d = m_div ? 32'd5 : 32'd4; end
      else if (m_preg != 0) begin s.we = 1; w.r = m_preg; w.d = res; end
    end else if (m_pend) begin
      stall = (kind == 2) || (kind == 1 && r == m_preg && m_preg != 0);
    end
    if (!stall && kind == 1) begin s.we = 1; w.r = r; w.d = dat; end
    s.stall = stall; s.busy = m_pend; s.pend = m_pend ? m_preg : 5'd0;
    statq.push_back(s);
    if (s.we) wq.push_back(w);
    if (m_pend && rdy) m_pend = 0;
    else if (!m_pend && kind == 2) begin m_pend = 1; m_preg = r; m_div = m_lat.insn[2]; end
    if (!stall) m_lat = t;
    last_acc = !stall;
  endtask

  task automatic expect_out(input string name, input bit we, input logic [4:0] r,
                            input logic [31:0] d, input bit st, input bit busy);
    @(negedge clock);
    chk({name, "_we"}, ctrl_writeEnable, we);
    chk({name, "_reg"}, ctrl_writeReg, r);
    chk({name, "_data"}, data_writeReg, d);
    chk({name, "_stall"}, wb_stall, st);
    chk({name, "_busy"}, md_busy, busy);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_stall"}, wb_stall, 0);
    chk({name, "_we"}, ctrl_writeEnable, 0);
    chk({name, "_reg"}, ctrl_writeReg, 0);
    chk({name, "_data"}, data_writeReg, 0);
    chk({name, "_busy"}, md_busy, 0);
    chk({name, "_pend"}, md_pendingReg, 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0; wb_valid_in = 1'b0; md_resultRDY = 1'b0;
    #1;
    check_zero("midreset");
    m_pend = 0; m_div = 0; m_preg = 0; m_lat = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Scoreboard monitor: every predicted cycle checks status, every DUT write pops the write queue
  stat_t e;
  wr_t   ew;
  always @(negedge clock) begin
    if (reset === 1'b1 && statq.size() > 0) begin
      e = statq.pop_front();
      chk("sb_stall", wb_stall, e.stall);
      chk("sb_busy", md_busy, e.busy);
      chk("sb_pendreg", md_pendingReg, e.pend);
      chk("sb_we", ctrl_writeEnable, e.we);
      if (!ctrl_writeEnable) chk("sb_idle_port", {ctrl_writeReg, data_writeReg}, 0);
    end
    if (ctrl_writeEnable === 1'b1) begin
      if (wq.size() == 0) begin
        chk("sb_spurious_write", 1, 0);
      end else begin
        ew = wq.pop_front();
        chk("sb_wreg", ctrl_writeReg, ew.r);
        chk("sb_wdata", data_writeReg, ew.d);
      end
    end
  end

  function automatic txn_t rand_txn();
    txn_t t;
    logic [4:0] ops[8] = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd8, 5'd3, 5'd21, 5'd2};
    logic [4:0] alus[4] = '{5'd0, 5'd1, 5'd6, 5'd7};
    logic [4:0] op, alu;
    op  = ops[$urandom_range(0, 7)];
    alu = (op == 0) ? alus[$urandom_range(0, 3)] : 5'($urandom_range(0, 31));
    t.v    = ($urandom_range(0, 4) != 0);
    t.insn = {op, 5'($urandom_range(0, 12)), 15'($urandom), alu, 2'($urandom)};
    t.o    = $urandom;
    t.d    = $urandom;
    t.pc   = $urandom;
    t.exc  = (op == 0 && alu < 6 && $urandom_range(0, 9) == 0);
    t.code = 3'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    txn_t t;
    int n;
    reset = 1'b0; wb_valid_in = 0; insn_in = 0; o_in = 0; d_in = 0; pcPlus1_in = 0;
    exc_in = 0; excCode_in = 0; md_resultRDY = 0; md_result = 0; md_exception = 0;
    m_pend = 0; m_div = 0; m_preg = 0; m_lat = '0;
    #2;
    check_zero("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // addi, jal, setx, r0
    step(tx(mk(5'd5, 5'd5, 5'd0), 32'd7));
    step(bub());                              expect_out("addi", 1, 5, 32'd7, 0, 0);
    step(tx(mk(5'd3, 5'd0, 5'd0), 0, 0, 32'h40));
    step(tx({5'b10101, 27'h123}, 0));          expect_out("jal", 1, 31, 32'h40, 0, 0);
    step(tx(mk(5'd0, 5'd0, 5'd0), 32'd5));     expect_out("setx", 1, 30, 32'h123, 0, 0);
    step(bub());                              expect_out("add_r0", 0, 0, 0, 0, 0);

    // mul, independent add, result
    step(tx(mk(5'd0, 5'd4, 5'd6), 0));
    step(tx(mk(5'd0, 5'd6, 5'd0), 32'd9));     expect_out("mul_latched", 0, 0, 0, 0, 0);
    step(bub());                              expect_out("indep_add", 1, 6, 32'd9, 0, 1);
    chk("mul_pendreg", md_pendingReg, 4);
    step(bub(), 1, 32'h2A);                   expect_out("mul_result", 1, 4, 32'h2A, 0, 1);
    step(bub());                              expect_out("mul_idle", 0, 0, 0, 0, 0);

    // collision between result and latched lw
    step(tx(mk(5'd0, 5'd4, 5'd6), 0));
    step(bub());
    step(tx(mk(5'd8, 5'd7, 5'd0), 0, 32'h77));  expect_out("coll_pre", 0, 0, 0, 0, 1);
    step(bub(), 1, 32'h11);                   expect_out("coll_md", 1, 4, 32'h11, 1, 1);
    step(bub());                              expect_out("coll_lw", 1, 7, 32'h77, 0, 0);

    // WAW on r9
    step(tx(mk(5'd0, 5'd9, 5'd6), 0));
    step(bub());
    step(tx(mk(5'd0, 5'd9, 5'd0), 32'h99));    expect_out("waw_pre", 0, 0, 0, 0, 1);
    step(bub());                              expect_out("waw_hold1", 0, 0, 0, 1, 1);
    step(bub());                              expect_out("waw_hold2", 0, 0, 0, 1, 1);
    step(bub(), 1, 32'h55);                   expect_out("waw_md", 1, 9, 32'h55, 1, 1);
    step(bub());                              expect_out("waw_add", 1, 9, 32'h99, 0, 0);

    // second mul/div behind an outstanding one, then div exception
    step(tx(mk(5'd0, 5'd9, 5'd6), 0));
    step(bub());
    step(tx(mk(5'd0, 5'd12, 5'd7), 0));        expect_out("div2_pre", 0, 0, 0, 0, 1);
    step(bub());                              expect_out("div2_hold", 0, 0, 0, 1, 1);
    step(bub(), 1, 32'h66);                   expect_out("div2_first", 1, 9, 32'h66, 1, 1);
    step(bub());                              expect_out("div2_retire", 0, 0, 0, 0, 0);
    step(bub());                              expect_out("div2_pend", 0, 0, 0, 0, 1);
    chk("div2_pendreg", md_pendingReg, 12);
    step(bub(), 1, 32'h1234, 1);              expect_out("div_exc", 1, 30, 32'd5, 0, 1);
    step(bub());                              expect_out("div_exc_idle", 0, 0, 0, 0, 0);

    // ALU overflow exception
    step(tx(mk(5'd0, 5'd3, 5'd0), 32'h1234, 0, 0, 1'b1, 3'd1));
    step(bub());                              expect_out("add_exc", 1, 30, 32'd1, 0, 0);

    // reset during PENDING
    step(tx(mk(5'd0, 5'd8, 5'd6), 0));
    step(bub());
    step(bub());                              expect_out("rst_pend", 0, 0, 0, 0, 1);
    do_reset();
    step(bub(), 1, 32'h77);                   expect_out("rst_ignored", 0, 0, 0, 0, 0);

    // randomized traffic, upstream holding its outputs while stalled
    for (int i = 0; i < 1500; i++) begin
      t = rand_txn();
      n = 0;
      last_acc = 1'b0;
      while (!last_acc) begin
        step(t, m_pend ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0),
             $urandom, ($urandom_range(0, 7) == 0));
        n++;
        if (n > 200) begin
          chk("stall_timeout", n, 0);
          break;
        end
      end
    end
    step(bub());
    @(negedge clock); #1;
    chk("drain_writes", wq.size(), 0);
    chk("drain_status", statq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
